// File: rtl/acs_array_pm.sv
// acs_array_pm: registered add-compare-select array with saturating path metrics and MSB-clear normalisation
module acs_array_pm #(
  parameter int K = 3,
  parameter int PM_W = 4,
  parameter int BM_W = 2,
  parameter int NORM_EN = 1,
  parameter int CNT_W = 8,
  localparam int NS = 2**(K-1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   bm_valid,
  input  logic [2*NS*BM_W-1:0]   bm,
  output logic                   dec_valid,
  output logic [NS-1:0]          dec,
  output logic [NS*PM_W-1:0]     pm_out,
  output logic [K-2:0]           best_state,
  output logic                   norm_evt,
  output logic [CNT_W-1:0]       step_cnt
);
  localparam logic [PM_W-1:0] MAX = '1;
  logic [PM_W-1:0] pm [NS];
  logic [PM_W-1:0] npm [NS];
  logic [PM_W-1:0] spm [NS];
  logic [NS-1:0] d, msb;
  logic norm;
  logic [K-2:0] best;
  for (genvar s = 0; s < NS; s++) begin : g_acs
    localparam int P0 = (2*s) % NS;
    logic [PM_W:0] a0, a1;
    logic [PM_W-1:0] s0, s1;
    assign a0 = {1'b0, pm[P0]} + {{(PM_W+1-BM_W){1'b0}}, bm[(2*s)*BM_W +: BM_W]};
    assign a1 = {1'b0, pm[P0+1]} + {{(PM_W+1-BM_W){1'b0}}, bm[(2*s+1)*BM_W +: BM_W]};
    assign s0 = a0[PM_W] ? MAX : a0[PM_W-1:0];
    assign s1 = a1[PM_W] ? MAX : a1[PM_W-1:0];
    assign d[s] = s0 > s1;
    assign npm[s] = d[s] ? s1 : s0;
    assign msb[s] = npm[s][PM_W-1];
    assign spm[s] = norm ? {1'b0, npm[s][PM_W-2:0]} : npm[s];
    assign pm_out[s*PM_W +: PM_W] = pm[s];
  end
  // every metric carries the MSB only when all of them are at least HALF
  assign norm = (NORM_EN != 0) && (&msb);
  always_comb begin
    best = '0;
    for (int i = 1; i < NS; i++) best = spm[i] < spm[best] ? (K-1)'(i) : best;
  end
  always_ff @(posedge clk) begin
    if (reset || start) begin
      for (int i = 0; i < NS; i++) pm[i] <= (i == 0) ? '0 : MAX;
      dec <= '0;
      dec_valid <= 1'b0;
      best_state <= '0;
      norm_evt <= 1'b0;
      step_cnt <= '0;
    end else if (bm_valid) begin
      for (int i = 0; i < NS; i++) pm[i] <= spm[i];
      dec <= d;
      dec_valid <= 1'b1;
      best_state <= best;
      norm_evt <= norm;
      step_cnt <= step_cnt + CNT_W'(1);
    end else begin
      dec_valid <= 1'b0;
      norm_evt <= 1'b0;
    end
  end
endmodule

// File: tb/tb_acs_array_pm.sv
// tb_acs_array_pm: randomized self-checking bench against an arithmetic Viterbi ACS model
module tb_acs_array_pm;
  logic clk = 0;
  logic reset = 1, start = 0, bm_valid = 0;
  logic [15:0] bm = '0;
  logic dec_valid, norm_evt;
  logic [3:0] dec;
  logic [15:0] pm_out;
  logic [1:0] best_state;
  logic [7:0] step_cnt;
  int n_tests = 0, n_fail = 0;
  int mpm [4];
  logic [3:0] mdec;
  int mbest, mcnt;
  bit mdv, mnorm;

  acs_array_pm #(.K(3), .PM_W(4), .BM_W(2), .NORM_EN(1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .bm_valid(bm_valid), .bm(bm),
    .dec_valid(dec_valid), .dec(dec), .pm_out(pm_out), .best_state(best_state),
    .norm_evt(norm_evt), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit rs, input bit st, input bit v, input logic [15:0] b);
    int np [4];
    int mn;
    if (rs || st) begin
      mpm = '{0, 15, 15, 15};
      mdec = '0; mbest = 0; mcnt = 0; mdv = 0; mnorm = 0;
    end else if (v) begin
      for (int s = 0; s < 4; s++) begin
        int p = (2*s) % 4;
        int a0 = mpm[p] + int'(b[(2*s)*2 +: 2]);
        int a1 = mpm[p+1] + int'(b[(2*s+1)*2 +: 2]);
        if (a0 > 15) a0 = 15;
        if (a1 > 15) a1 = 15;
        mdec[s] = a0 > a1;
        np[s] = mdec[s] ? a1 : a0;
      end
      mn = np[0];
      for (int s = 1; s < 4; s++) if (np[s] < mn) mn = np[s];
      mnorm = mn >= 8;
      for (int s = 0; s < 4; s++) mpm[s] = mnorm ? np[s] - 8 : np[s];
      mbest = 0;
      for (int s = 3; s >= 0; s--) if (mpm[s] == mn - (mnorm ? 8 : 0)) mbest = s;
      mcnt = (mcnt + 1) % 256;
      mdv = 1;
    end else begin
      mdv = 0; mnorm = 0;
    end
  endtask

  function automatic logic [15:0] exp_pm();
    for (int s = 0; s < 4; s++) exp_pm[s*4 +: 4] = 4'(mpm[s]);
  endfunction

  task automatic step(input bit rs, input bit st, input bit v, input logic [15:0] b);
    reset = rs; start = st; bm_valid = v; bm = b;
    @(posedge clk);
    #1;
    model_step(rs, st, v, b);
    reset = 0; start = 0; bm_valid = 0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 16'hFFFF);
    n_tests++; if (pm_out !== 16'hFFF0) begin n_fail++; $display("FAIL reset_pm got %h want fff0", pm_out); end
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", dec_valid); end
    n_tests++; if (step_cnt !== 8'd0 || best_state !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_best got %0d/%0d want 0/0", step_cnt, best_state); end
    n_tests++; if (dec !== 4'd0 || norm_evt !== 1'b0) begin n_fail++; $display("FAIL reset_dec_norm got %b/%b want 0000/0", dec, norm_evt); end
  endtask

  task automatic test_first_step();
    step(0, 1, 0, 16'h0);
    n_tests++; if (dec_valid !== 1'b0 || pm_out !== 16'hFFF0) begin n_fail++; $display("FAIL start_init got dv=%b pm=%h want 0/fff0", dec_valid, pm_out); end
    step(0, 0, 1, 16'h0001);
    n_tests++; if (pm_out[3:0] !== 4'd1 || pm_out[11:8] !== 4'd0) begin n_fail++; $display("FAIL first_pm got %h want pm0=1 pm2=0", pm_out); end
    n_tests++; if (dec[0] !== 1'b0 || best_state !== 2'd2) begin n_fail++; $display("FAIL first_dec_best got %b/%0d want d0=0/2", dec, best_state); end
    n_tests++; if (dec_valid !== 1'b1 || step_cnt !== 8'd1) begin n_fail++; $display("FAIL first_dv_cnt got %b/%0d want 1/1", dec_valid, step_cnt); end
    n_tests++; if (pm_out !== exp_pm() || dec !== mdec) begin n_fail++; $display("FAIL first_model got %h/%b want %h/%b", pm_out, dec, exp_pm(), mdec); end
  endtask

  task automatic test_saturate();
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'hFFFF);
    n_tests++; if (pm_out[7:4] !== 4'd15 || dec[1] !== 1'b0) begin n_fail++; $display("FAIL saturate got pm1=%0d d1=%b want 15/0", pm_out[7:4], dec[1]); end
    n_tests++; if (pm_out !== exp_pm()) begin n_fail++; $display("FAIL saturate_model got %h want %h", pm_out, exp_pm()); end
  endtask

  task automatic test_norm();
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'hFFFF);
    step(0, 0, 1, 16'hFFFF);
    n_tests++; if (pm_out !== 16'h6666 || norm_evt !== 1'b0) begin n_fail++; $display("FAIL pre_norm got %h/%b want 6666/0", pm_out, norm_evt); end
    step(0, 0, 1, 16'hFFFF);
    n_tests++; if (pm_out !== 16'h1111 || norm_evt !== 1'b1) begin n_fail++; $display("FAIL norm got %h/%b want 1111/1", pm_out, norm_evt); end
    step(0, 0, 0, 16'hFFFF);
    n_tests++; if (norm_evt !== 1'b0 || pm_out !== 16'h1111 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL norm_pulse got %b/%h/%b want 0/1111/0", norm_evt, pm_out, dec_valid); end
    step(0, 0, 1, 16'hFFFF);
    step(0, 0, 1, 16'hFFFF);
    n_tests++; if (pm_out !== 16'h7777 || norm_evt !== 1'b0) begin n_fail++; $display("FAIL no_norm7 got %h/%b want 7777/0", pm_out, norm_evt); end
  endtask

  task automatic test_priority();
    step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h1234);
    step(0, 1, 1, 16'h5678);
    n_tests++; if (pm_out !== 16'hFFF0 || dec_valid !== 1'b0 || step_cnt !== 8'd0) begin n_fail++; $display("FAIL start_over_valid got %h/%b/%0d want fff0/0/0", pm_out, dec_valid, step_cnt); end
    step(0, 0, 1, 16'h9ABC);
    step(0, 0, 1, 16'hDEF0);
    step(1, 1, 1, 16'h1111);
    n_tests++; if (pm_out !== 16'hFFF0 || dec_valid !== 1'b0 || step_cnt !== 8'd0 || dec !== 4'd0) begin n_fail++; $display("FAIL reset_mid got %h/%b/%0d/%b want fff0/0/0/0", pm_out, dec_valid, step_cnt, dec); end
  endtask

  task automatic test_random();
    step(0, 1, 0, 16'h0);
    for (int i = 0; i < 400; i++) begin
      bit v = $urandom_range(9, 0) < 7;
      bit st = $urandom_range(49, 0) == 0;
      step(0, st, v, 16'($urandom));
      n_tests++;
      if (pm_out !== exp_pm() || dec !== mdec || best_state !== 2'(mbest) || dec_valid !== mdv || norm_evt !== mnorm || step_cnt !== 8'(mcnt)) begin
        n_fail++;
        $display("FAIL random[%0d] got pm=%h d=%b b=%0d dv=%b n=%b c=%0d want pm=%h d=%b b=%0d dv=%b n=%b c=%0d", i, pm_out, dec, best_state, dec_valid, norm_evt, step_cnt, exp_pm(), mdec, mbest, mdv, mnorm, mcnt);
      end
    end
  endtask

  task automatic test_wrap();
    step(0, 1, 0, 16'h0);
    for (int i = 0; i < 255; i++) step(0, 0, 1, 16'($urandom));
    n_tests++; if (step_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt255 got %0d want 255", step_cnt); end
    step(0, 0, 1, 16'($urandom));
    n_tests++; if (step_cnt !== 8'd0 || dec_valid !== 1'b1) begin n_fail++; $display("FAIL cnt_wrap got %0d/%b want 0/1", step_cnt, dec_valid); end
    n_tests++; if (pm_out !== exp_pm() || best_state !== 2'(mbest)) begin n_fail++; $display("FAIL wrap_model got %h/%0d want %h/%0d", pm_out, best_state, exp_pm(), mbest); end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_saturate();
    test_norm();
    test_priority();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
